// File: rtl/alu_issue.sv
`default_nettype none
// ============================================================================
// Module   : alu_issue
// Purpose  : Execute-stage sequencer that issues one instruction at a time to
//            the integer/M ALU, holds its operands and writes back the result.
// Revision : 1.0 - initial release
// ============================================================================
module alu_issue #(
    parameter int TIMEOUT = 31,
    parameter int TW      = 5
) (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [6:0]  in_opcode,
    input  logic [2:0]  in_funct3,
    input  logic        in_modbit,
    input  logic [31:0] in_imm,
    input  logic [31:0] in_rs1_val,
    input  logic [31:0] in_rs2_val,
    input  logic [4:0]  in_rd_addr,
    input  logic        kill,
    output logic        alu_req,
    output logic [6:0]  alu_opcode,
    output logic [2:0]  alu_funct3,
    output logic        alu_modbit,
    output logic [31:0] alu_imm,
    output logic [31:0] alu_rs1,
    output logic [31:0] alu_rs2,
    input  logic [31:0] alu_rd,
    input  logic        alu_comp,
    output logic        wb_valid,
    output logic [4:0]  wb_addr,
    output logic [31:0] wb_data,
    output logic        illegal,
    output logic        err
);

    localparam logic [6:0] c_OP_IMM = 7'b0010011;
    localparam logic [6:0] c_OP_REG = 7'b0110011;

    localparam logic [2:0] c_IDLE  = 3'd0;
    localparam logic [2:0] c_ISSUE = 3'd1;
    localparam logic [2:0] c_WB    = 3'd2;
    localparam logic [2:0] c_ILL   = 3'd3;
    localparam logic [2:0] c_HALT  = 3'd4;

    localparam logic [TW-1:0] c_WD_LAST = TW'(TIMEOUT - 1);

    logic [2:0]    r_state;
    logic [2:0]    w_next;
    logic [TW-1:0] r_wdog;
    logic          r_killed;
    logic [6:0]    r_opcode;
    logic [2:0]    r_funct3;
    logic          r_modbit;
    logic [31:0]   r_imm;
    logic [31:0]   r_rs1;
    logic [31:0]   r_rs2;
    logic [4:0]    r_wb_addr;
    logic [31:0]   r_wb_data;
    logic          w_accept;
    logic          w_legal;
    logic          w_timeout;

    assign w_accept  = (r_state == c_IDLE) && in_valid;
    assign w_legal   = (in_opcode == c_OP_IMM) || (in_opcode == c_OP_REG);
    assign w_timeout = (r_wdog == c_WD_LAST);

    always_ff @(posedge clk) begin
        if (!reset) begin
            r_state <= c_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    // Leaving ISSUE on alu_comp guarantees alu_req drops the cycle after completion.
    always_comb begin
        w_next = r_state;
        case (r_state)
            c_IDLE: begin
                if (in_valid) begin
                    w_next = w_legal ? c_ISSUE : c_ILL;
                end
            end
            c_ISSUE: begin
                if (alu_comp) begin
                    w_next = c_WB;
                end else if (w_timeout) begin
                    w_next = c_HALT;
                end
            end
            c_WB:    w_next = c_IDLE;
            c_ILL:   w_next = c_IDLE;
            c_HALT:  w_next = c_HALT;
            default: w_next = c_IDLE;
        endcase
    end

    // Operand registers change only on accept, so they stay frozen while alu_req is high.
    always_ff @(posedge clk) begin
        if (!reset) begin
            r_wdog    <= '0;
            r_killed  <= 1'b0;
            r_opcode  <= '0;
            r_funct3  <= '0;
            r_modbit  <= 1'b0;
            r_imm     <= '0;
            r_rs1     <= '0;
            r_rs2     <= '0;
            r_wb_addr <= '0;
            r_wb_data <= '0;
        end else if (w_accept) begin
            r_wdog    <= '0;
            r_killed  <= 1'b0;
            r_opcode  <= in_opcode;
            r_funct3  <= in_funct3;
            r_modbit  <= in_modbit;
            r_imm     <= in_imm;
            r_rs1     <= in_rs1_val;
            r_rs2     <= in_rs2_val;
            r_wb_addr <= in_rd_addr;
        end else if (r_state == c_ISSUE) begin
            r_wdog <= r_wdog + 1'b1;
            if (kill) begin
                r_killed <= 1'b1;
            end
            if (alu_comp) begin
                r_wb_data <= alu_rd;
            end
        end
    end

    assign in_ready   = (r_state == c_IDLE);
    assign alu_req    = (r_state == c_ISSUE);
    assign wb_valid   = (r_state == c_WB) && !r_killed && (r_wb_addr != 5'd0);
    assign illegal    = (r_state == c_ILL);
    assign err        = (r_state == c_HALT);
    assign alu_opcode = r_opcode;
    assign alu_funct3 = r_funct3;
    assign alu_modbit = r_modbit;
    assign alu_imm    = r_imm;
    assign alu_rs1    = r_rs1;
    assign alu_rs2    = r_rs2;
    assign wb_addr    = r_wb_addr;
    assign wb_data    = r_wb_data;

endmodule
`default_nettype wire

// File: doc/alu_issue.md
Name: alu_issue

Overview:
- Execute-stage sequencer sitting directly upstream of the integer/M-extension ALU.
- Accepts one decoded instruction per valid/ready handshake and holds the ALU request and operands stable until the ALU signals completion.
- Captures the ALU result and emits a single-cycle register-file writeback.
- Also screens out non-ALU opcodes, supports a pipeline kill, and runs a watchdog against a hung ALU.

Parameters:
- TIMEOUT, 31: maximum cycles alu_req may stay high without alu_comp before the error trips. Must be greater than or equal to 9.
- TW, 5: width of the watchdog counter. Must satisfy 2^TW > TIMEOUT.

Ports:
- clk  in  1  system clock
- reset  in  1  synchronous, active-low reset; also drives the ALU reset
- in_valid  in  1  decoded instruction present
- in_ready  out  1  sequencer can accept an instruction
- in_opcode  in  7  instruction opcode
- in_funct3  in  3  funct3 field
- in_modbit  in  1  instr[30]; selects SUB/SRA
- in_imm  in  32  sign-extended immediate; bit 5 carries funct7[0] for R-type M-extension selection
- in_rs1_val  in  32  rs1 operand value
- in_rs2_val  in  32  rs2 operand value
- in_rd_addr  in  5  destination register
- kill  in  1  discard the in-flight result
- alu_req  out  1  ALU request
- alu_opcode  out  7  opcode to ALU
- alu_funct3  out  3  funct3 to ALU
- alu_modbit  out  1  modbit to ALU
- alu_imm  out  32  immediate to ALU
- alu_rs1  out  32  rs1 operand to ALU
- alu_rs2  out  32  rs2 operand to ALU
- alu_rd  in  32  ALU result
- alu_comp  in  1  ALU completion; high for exactly one cycle
- wb_valid  out  1  register-file write strobe, one-cycle pulse
- wb_addr  out  5  write address
- wb_data  out  32  write data
- illegal  out  1  one-cycle pulse: opcode is not 0010011 or 0110011
- err  out  1  sticky watchdog error

Behaviour:
- Reset (reset==0 at a clk edge):
  - State goes to IDLE.
  - alu_req, wb_valid, illegal and err are all 0.
  - wb_addr, wb_data and all alu_* operand registers are 0.
  - The watchdog counter is 0.
  - Reset mid-operation abandons the instruction with no writeback. The ALU resets on the same edge.
- States:
  - IDLE: in_ready=1. On in_valid, latch all in_* fields into the alu_* and rd registers.
    - Legal opcode: go to ISSUE.
    - Other opcode: go to ILL.
  - ISSUE: alu_req=1 and the watchdog counts up.
    - On alu_comp: capture alu_rd into wb_data and go to WB.
    - When the counter reaches TIMEOUT with no alu_comp: go to HALT.
  - WB: alu_req=0. wb_valid=1 for this cycle only, unless suppressed (see the kill and x0 rules). Go to IDLE.
  - ILL: illegal=1 for one cycle, no ALU request, no writeback. Go to IDLE.
  - HALT: alu_req=0, in_ready=0, err=1. Leave only by reset.
- in_ready is 1 only in IDLE. No instruction is accepted in ISSUE, WB, ILL or HALT.
- alu_* outputs must remain constant from the accept edge until alu_req falls. The divide path re-reads funct3 late, so this is required.
- alu_req must be 0 in the cycle after alu_comp. Otherwise the ALU re-executes from its IDLE state.
- Latency, with the accept edge at end of cycle 0:
  - ADD-class and MUL: alu_req in cycles 1–2, alu_comp in cycle 2, wb_valid in cycle 3.
  - DIV/DIVU/REM/REMU: alu_comp in cycle 9, wb_valid in cycle 10.
  - Next accept is possible in cycle 4 (simple ops) or cycle 11 (divide).
- kill:
  - If kill is high in any cycle from the accept edge through the alu_comp cycle, the instruction is marked killed.
  - A killed instruction still waits for alu_comp, because the ALU cannot be aborted.
  - In WB, wb_valid stays 0 for a killed instruction.
  - kill in IDLE or WB has no effect.
- x0 rule: wb_addr==0 suppresses wb_valid. wb_data is still updated.
- The watchdog clears on every accept.
- alu_comp seen outside ISSUE is ignored.

Test Plan:
- ADDI (0010011, funct3=000) with rs1=5, imm=0xFFFFFFFD, rd=7 -> wb_valid in cycle 3, wb_addr=7, wb_data=2; in_ready=1 in cycle 4.
- DIVU (0110011, funct3=101, imm[5]=1) with rs1=100, rs2=7, rd=3 -> alu_req held for cycles 1–9 with operands unchanged, wb_valid in cycle 10, wb_data=14; a second in_valid in cycle 5 is not accepted.
- SUB (modbit=1) with rs1=3, rs2=5, rd=0 -> wb_valid stays 0, wb_data=0xFFFFFFFE; then ADD with rd=1 writes normally.
- REM with kill pulsed in cycle 4 -> alu_req held until alu_comp in cycle 9, wb_valid=0 in cycle 10, in_ready=1 in cycle 11.
- Opcode 0000011 -> illegal=1 in cycle 1, alu_req never asserted, no wb_valid, in_ready=1 in cycle 2.
- Stub ALU that never asserts alu_comp, TIMEOUT=31 -> err=1 and alu_req=0 by cycle 33, in_ready stays 0; reset low for one edge -> err=0 and in_ready=1.
- Reset asserted in cycle 5 of a DIV -> no wb_valid; a following ADDI completes with normal latency.
